// File: rtl/flex_fifo.sv
// flex_fifo: first-word-fall-through FIFO of any depth; define FLEX_FIFO_ERR_FLAGS_EN for sticky overflow/underflow flags
module flex_fifo #(
    parameter int DATA_BIT_WIDTH = 32,
    parameter int DEPTH          = 32,
    parameter int AF_THRESH      = DEPTH - 2,
    parameter int AE_THRESH      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [DATA_BIT_WIDTH-1:0]   in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_BIT_WIDTH-1:0]   out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH+1)-1:0]  level,
    output logic                        almost_full,
`ifdef FLEX_FIFO_ERR_FLAGS_EN
    input  logic                        err_clr,
    output logic                        overflow,
    output logic                        underflow,
`endif
    output logic                        almost_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L = LW'(AE_THRESH);

    logic [DATA_BIT_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic wr, rd;

    always_comb begin
        in_ready  = (level_q < FULL) && !flush;
        out_valid = (level_q != '0) && !flush;
        wr = in_valid && in_ready;
        rd = out_valid && out_ready;
        // pointers wrap explicitly so non-power-of-two depths work
        w_ptr_d = flush ? '0 : wr ? ((w_ptr_q == LAST) ? '0 : w_ptr_q + 1'b1) : w_ptr_q;
        r_ptr_d = flush ? '0 : rd ? ((r_ptr_q == LAST) ? '0 : r_ptr_q + 1'b1) : r_ptr_q;
        level_d = flush ? '0 : (wr && !rd) ? level_q + 1'b1 : (rd && !wr) ? level_q - 1'b1 : level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            level_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !rst) mem_q[w_ptr_q] <= in_data;
    end

    assign out_data     = mem_q[r_ptr_q];
    assign level        = level_q;
    assign almost_full  = level_q >= AF_L;
    assign almost_empty = level_q <= AE_L;

`ifdef FLEX_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    always_comb begin
        overflow_d  = !err_clr && (overflow_q || (in_valid && !in_ready && !flush));
        underflow_d = !err_clr && (underflow_q || (out_ready && !out_valid && !flush));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif
endmodule

// File: doc/flex_fifo.md
FLEX_FIFO -- requirements
Module: flex_fifo

Interface
REQ-001 The block SHALL have parameter DATA_BIT_WIDTH, default 32, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 32, storage entries (>=2, any integer, not restricted to powers of two).
REQ-003 The block SHALL have parameter AF_THRESH, default DEPTH-2, level at or above which almost_full asserts (1..DEPTH).
REQ-004 The block SHALL have parameter AE_THRESH, default 2, level at or below which almost_empty asserts (0..DEPTH-1).
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: ports clk (input, 1, rising-edge clock) and rst (input, 1, async active-high reset).
REQ-006 The block SHALL have port flush (input, 1): synchronous clear of contents.
REQ-007 The block SHALL have port in_data (input, DATA_BIT_WIDTH): write data.
REQ-008 The block SHALL have port in_valid (input, 1): write request.
REQ-009 The block SHALL have port in_ready (output, 1): space available.
REQ-010 The block SHALL have port out_data (output, DATA_BIT_WIDTH): head-of-queue data.
REQ-011 The block SHALL have port out_valid (output, 1): data available.
REQ-012 The block SHALL have port out_ready (input, 1): read acknowledge.
REQ-013 The block SHALL have port level (output, $clog2(DEPTH+1)): current occupancy.
REQ-014 The block SHALL have ports almost_full and almost_empty (output, 1 each): threshold flags.

Function
REQ-015 Write transfer SHALL occur on a rising clk edge with in_valid && in_ready; in_data is stored at w_ptr, and w_ptr advances.
REQ-016 Read transfer SHALL occur on a rising clk edge with out_valid && out_ready; r_ptr advances.
REQ-017 Output SHALL be first-word-fall-through: out_data = mem[r_ptr], combinational, valid in the same cycle out_valid rises (write-to-out_valid latency 1 cycle).
REQ-018 in_ready SHALL be (level < DEPTH) && !flush; out_valid SHALL be (level > 0) && !flush; both combinational.
REQ-019 Pointers SHALL wrap explicitly from DEPTH-1 to 0, with no reliance on power-of-two overflow.
REQ-020 level SHALL track occupancy: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
REQ-021 Simultaneous write and read when level==DEPTH SHALL be impossible (in_ready=0); when level==0, only the write SHALL complete (out_valid=0).
REQ-022 almost_full SHALL equal (level >= AF_THRESH); almost_empty SHALL equal (level <= AE_THRESH); both derived combinationally from the level register.
REQ-023 flush high at a clk edge SHALL zero w_ptr, r_ptr and level, overriding any write or read that cycle; memory contents are not cleared.
REQ-024 Data order SHALL be strictly first-in-first-out; no word SHALL be dropped or duplicated.

Reset
REQ-025 Asserting rst SHALL asynchronously force w_ptr=0, r_ptr=0 and level=0; consequently in_ready=1, out_valid=0, almost_empty=1, almost_full=0, and error flags=0.
REQ-026 Memory SHALL NOT be reset; out_data SHALL be don't-care while out_valid=0.
REQ-027 rst asserted mid-transfer SHALL discard all contents, with no partial write completing.
REQ-028 Normal operation SHALL resume on the first rising clk edge after rst deasserts.

Configuration
REQ-029 Macro FLEX_FIFO_ERR_FLAGS_EN, when defined, SHALL add input err_clr (1), output overflow (1) and output underflow (1).
REQ-030 With FLEX_FIFO_ERR_FLAGS_EN defined, overflow SHALL set (sticky) on a clk edge with in_valid && !in_ready && !flush.
REQ-031 With FLEX_FIFO_ERR_FLAGS_EN defined, underflow SHALL set (sticky) on a clk edge with out_ready && !out_valid && !flush.
REQ-032 With FLEX_FIFO_ERR_FLAGS_EN defined, err_clr SHALL clear both flags, with clear taking priority over set in the same cycle; rst SHALL clear both flags.
REQ-033 Without FLEX_FIFO_ERR_FLAGS_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 The bench SHALL cover fill and drain: DEPTH=5, write 0x11..0x55 -> in_ready=0 and level=5 after the 5th write; reads return 0x11..0x55 in order; level=0.
REQ-035 The bench SHALL cover wrap: DEPTH=5, 3 writes, 3 reads, then 4 writes -> pointers wrap past 4 and data reads back in order.
REQ-036 The bench SHALL cover simultaneous transfers: level=3, in_valid=out_ready=1 for 10 cycles -> level stays 3 and the output stream matches the input stream delayed by 3.
REQ-037 The bench SHALL cover thresholds: DEPTH=8, AF_THRESH=6, AE_THRESH=1 -> almost_empty=1 at levels 0-1, 0 at level 2; almost_full=1 at levels 6-8.
REQ-038 The bench SHALL cover flush and reset: level=4, flush pulse concurrent with a write -> level=0 next cycle and the write is dropped; rst asserted mid-cycle -> out_valid=0 immediately, without waiting for clk.
REQ-039 The bench SHALL cover error flags (with FLEX_FIFO_ERR_FLAGS_EN defined): write when full -> overflow=1 and stays set; read when empty -> underflow=1; err_clr pulse -> both flags 0.
